stack_initiator: RTL and testbench
==================================

STACK_INITIATOR -- requirements
Module: stack_initiator

Interface
REQ-001 Parameters SHALL be:
- DEPTH, default 4, capacity of the attached stack.
- TIMEOUT, default 16, maximum wait cycles for ready.
- CW, default $clog2(DEPTH+1), width of the occupancy count.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = push, 0 = pop.
- cmd_data  in  32  push data.
- valid  out  1  request to stack.
- ready  in  1  stack accepts request.
- write  out  1  push/pop select to stack.
- data_wr  out  32  push data to stack.
- data_rd  in  32  pop data from stack, valid in the handshake cycle.
- err  in  1  stack overflow/underflow, valid in the handshake cycle.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts response.
- rsp_write  out  1  echo of the command type.
- rsp_data  out  32  popped data; 0 for push, error or timeout.
- rsp_err  out  1  err sampled at the handshake.
- rsp_timeout  out  1  request aborted, no handshake occurred.
- rsp_mismatch  out  1  sampled err differs from the predicted err.
- occupancy  out  CW  shadow stack depth.

Function
REQ-003 The FSM SHALL have states IDLE, REQ and RSP; cmd_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE, cmd_valid&&cmd_ready SHALL register cmd_write/cmd_data into write/data_wr and move to REQ on the next edge.
REQ-005 In REQ, valid SHALL be 1, and write/data_wr SHALL stay stable until the handshake or timeout.
REQ-006 A handshake (valid&&ready in REQ) SHALL capture err and data_rd at that edge, move to RSP, and drop valid in the next cycle.
REQ-007 Latency SHALL be: cmd accept -> valid high 1 cycle later; handshake -> rsp_valid high 1 cycle later.
REQ-008 In RSP, rsp_valid SHALL be 1, and response fields SHALL hold stable until rsp_valid&&rsp_ready, which returns the FSM to IDLE.
REQ-009 rsp_data SHALL equal the captured data_rd for a pop with err=0, and 0 otherwise.
REQ-010 The predicted error SHALL be: push with occupancy==DEPTH, or pop with occupancy==0.
REQ-011 rsp_mismatch SHALL be 1 iff the captured err differs from the predicted error.
REQ-012 On a handshake with err=0, occupancy SHALL increment for a push and decrement for a pop.
REQ-013 On a handshake with err=1, occupancy SHALL be unchanged.
REQ-014 occupancy SHALL saturate at 0 and at DEPTH, and never wrap.
REQ-015 A wait counter SHALL clear on entry to REQ and count each REQ cycle with ready=0.
REQ-016 When the wait counter reaches TIMEOUT, the FSM SHALL abort to RSP with rsp_timeout=1, rsp_err=0, rsp_data=0 and occupancy unchanged, and valid SHALL drop in the next cycle.
REQ-017 If ready rises in the same cycle the counter reaches TIMEOUT, the handshake SHALL win and rsp_timeout SHALL be 0.
REQ-018 rsp_timeout and rsp_err SHALL never both be 1.
REQ-019 cmd_valid SHALL be ignored outside IDLE, and no command SHALL be lost or duplicated.

Reset
REQ-020 While reset is 1, the FSM SHALL be in IDLE, and valid, write, data_wr, rsp_* outputs, occupancy, cmd_ready and the wait counter SHALL be 0.
REQ-021 Reset SHALL take effect asynchronously.
REQ-022 Reset mid-REQ or mid-RSP SHALL drop valid/rsp_valid immediately, discard the pending command and response, and zero occupancy.
REQ-023 cmd_ready SHALL be 1 on the first clk edge after reset deasserts.

Verification
REQ-024 Push 0xA5A5_0001, then pop, with the stack model (DEPTH=4, random ready delay 0..7) -> rsp_data=0xA5A5_0001, rsp_err=0, rsp_mismatch=0, occupancy goes 0->1->0.
REQ-025 Five pushes at DEPTH=4 -> fifth push gives rsp_err=1, rsp_mismatch=0, occupancy stays 4; pops then return values in LIFO order.
REQ-026 Pop immediately after reset -> rsp_err=1, rsp_data=0, occupancy=0.
REQ-027 Ready tied low with TIMEOUT=16 -> valid high for exactly 16 cycles, then rsp_timeout=1, occupancy unchanged.
REQ-028 Ready rises on cycle 16 of REQ -> normal response with rsp_timeout=0.
REQ-029 rsp_ready held low 10 cycles while a new cmd_valid is presented -> response held stable, cmd_ready=0, command accepted only after the response is consumed.
REQ-030 Reset asserted while valid=1 -> valid=0 with no clock edge, occupancy=0, next command proceeds normally.

Source files
------------

// File: rtl/stack_initiator.sv
// stack_initiator: turns host push/pop commands into single valid/ready
// requests to an attached stack. It also keeps a shadow occupancy count that is
// used to predict overflow/underflow, and it aborts requests that wait too long
// for ready.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             host command handshake
//   cmd_write, cmd_data             command type (1 = push) and push data
//   valid/ready, write, data_wr     request to the stack
//   data_rd, err                    stack reply, sampled in the handshake cycle
//   rsp_valid/rsp_ready             host response handshake
//   rsp_write, rsp_data             echoed command type and popped data
//   rsp_err, rsp_timeout            stack error / aborted request
//   rsp_mismatch                    sampled err differs from the predicted err
//   occupancy                       shadow stack depth
module stack_initiator #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [31:0]   cmd_data,
    output logic          valid,
    input  logic          ready,
    output logic          write,
    output logic [31:0]   data_wr,
    input  logic [31:0]   data_rd,
    input  logic          err,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_write,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic          rsp_mismatch,
    output logic [CW-1:0] occupancy
);

    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_hs;
    logic            w_to;
    logic            w_pred_err;

    logic            r_cmd_ready;
    logic            r_valid;
    logic            r_write;
    logic [31:0]     r_data_wr;
    logic [WW-1:0]   r_wait;
    logic            r_rsp_valid;
    logic            r_rsp_write;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_err;
    logic            r_rsp_timeout;
    logic            r_rsp_mismatch;
    logic [CW-1:0]   r_occ;

    // Error the stack should report, based on the shadow depth
    assign w_pred_err = r_write ? (r_occ == CW'(DEPTH)) : (r_occ == '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; ready is checked first so a handshake on the last wait cycle beats the timeout
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_hs     = 1'b0;
        w_to     = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept = 1'b1;
                    w_next   = REQ;
                end
            end
            REQ: begin
                if (ready) begin
                    w_hs   = 1'b1;
                    w_next = RSP;
                end else if (r_wait == WW'(TIMEOUT - 1)) begin
                    // This cycle would be the TIMEOUT-th one without ready
                    w_to   = 1'b1;
                    w_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs, request/response payloads, wait counter and shadow occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_ready    <= 1'b0;
            r_valid        <= 1'b0;
            r_write        <= 1'b0;
            r_data_wr      <= '0;
            r_wait         <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_write    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_rsp_timeout  <= 1'b0;
            r_rsp_mismatch <= 1'b0;
            r_occ          <= '0;
        end else begin
            r_cmd_ready <= (w_next == IDLE);
            r_valid     <= (w_next == REQ);
            r_rsp_valid <= (w_next == RSP);

            if (w_accept) begin
                r_write   <= cmd_write;
                r_data_wr <= cmd_data;
                r_wait    <= '0;
            end else if (r_state == REQ && !ready) begin
                r_wait <= r_wait + WW'(1);
            end

            if (w_hs) begin
                r_rsp_write    <= r_write;
                r_rsp_err      <= err;
                r_rsp_timeout  <= 1'b0;
                r_rsp_data     <= (!r_write && !err) ? data_rd : 32'd0;
                r_rsp_mismatch <= (err != w_pred_err);
                // Saturate so an unexpected success at a boundary cannot wrap the count
                if (!err) begin
                    if (r_write && r_occ != CW'(DEPTH)) begin
                        r_occ <= r_occ + CW'(1);
                    end else if (!r_write && r_occ != '0) begin
                        r_occ <= r_occ - CW'(1);
                    end
                end
            end else if (w_to) begin
                r_rsp_write    <= r_write;
                r_rsp_err      <= 1'b0;
                r_rsp_timeout  <= 1'b1;
                r_rsp_data     <= 32'd0;
                r_rsp_mismatch <= 1'b0;
            end
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign valid        = r_valid;
    assign write        = r_write;
    assign data_wr      = r_data_wr;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_write    = r_rsp_write;
    assign rsp_data     = r_rsp_data;
    assign rsp_err      = r_rsp_err;
    assign rsp_timeout  = r_rsp_timeout;
    assign rsp_mismatch = r_rsp_mismatch;
    assign occupancy    = r_occ;

endmodule

// File: tb/tb_stack_initiator.sv
// Testbench for stack_initiator. It runs directed command vectors against a
// small behavioural stack. Each vector carries hand-computed expected response
// fields.
module tb_stack_initiator;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = 3;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [31:0]   cmd_data;
    logic          valid;
    logic          ready;
    logic          write;
    logic [31:0]   data_wr;
    logic [31:0]   data_rd;
    logic          err;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          rsp_mismatch;
    logic [CW-1:0] occupancy;

    stack_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_data     (cmd_data),
        .valid        (valid),
        .ready        (ready),
        .write        (write),
        .data_wr      (data_wr),
        .data_rd      (data_rd),
        .err          (err),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_write    (rsp_write),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_timeout  (rsp_timeout),
        .rsp_mismatch (rsp_mismatch),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inj: 0 = stack answers honestly, 1 = force err=1, 2 = force err=0
    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          delay;
        int          inj;
        int          hold;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_mis;
        logic        e_to;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t        tbl_a[18];
    vec_t        tbl_b[2];
    logic [31:0] mem[DEPTH];
    int          sp;
    int          n_chk;
    int          n_fail;

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d.%s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          n;
        logic        m_err;
        logic [31:0] rd;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_data  = v.data;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(idx, "cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = $urandom;
        chk(idx, "valid_lat", 32'(valid), 32'd1);
        chk(idx, "write", 32'(write), 32'(v.wr));
        chk(idx, "data_wr", data_wr, v.data);
        if (v.delay < TIMEOUT) begin
            repeat (v.delay) begin
                @(posedge clk); #1;
            end
            chk(idx, "valid_wait", 32'(valid), 32'd1);
            chk(idx, "data_wr_hold", data_wr, v.data);
            // Behavioural stack reply
            if (v.wr) begin
                m_err = (sp == DEPTH);
                rd    = 32'hBAD0_0000 ^ v.data;
            end else begin
                m_err = (sp == 0);
                rd    = (sp == 0) ? 32'hDEAD_BEEF : mem[sp-1];
            end
            if (v.inj == 1) m_err = 1'b1;
            if (v.inj == 2) m_err = 1'b0;
            ready   = 1'b1;
            err     = m_err;
            data_rd = rd;
            @(posedge clk); #1;
            ready   = 1'b0;
            err     = 1'b0;
            data_rd = $urandom;
            if (!m_err) begin
                if (v.wr && sp < DEPTH) begin
                    mem[sp] = v.data;
                    sp++;
                end else if (!v.wr && sp > 0) begin
                    sp--;
                end
            end
            chk(idx, "valid_drop", 32'(valid), 32'd0);
        end else begin
            n = 0;
            while (valid && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk(idx, "valid_cycles", 32'(n), 32'(TIMEOUT));
        end
        chk(idx, "rsp_valid", 32'(rsp_valid), 32'd1);
        chk(idx, "rsp_write", 32'(rsp_write), 32'(v.wr));
        chk(idx, "rsp_data", rsp_data, v.e_data);
        chk(idx, "rsp_err", 32'(rsp_err), 32'(v.e_err));
        chk(idx, "rsp_mismatch", 32'(rsp_mismatch), 32'(v.e_mis));
        chk(idx, "rsp_timeout", 32'(rsp_timeout), 32'(v.e_to));
        chk(idx, "occupancy", 32'(occupancy), 32'(v.e_occ));
        // Host stalls while offering another command
        if (v.hold > 0) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_data  = 32'hCAFE_F00D;
            repeat (v.hold) begin
                @(posedge clk); #1;
                chk(idx, "hold_rsp_valid", 32'(rsp_valid), 32'd1);
                chk(idx, "hold_rsp_data", rsp_data, v.e_data);
                chk(idx, "hold_rsp_err", 32'(rsp_err), 32'(v.e_err));
                chk(idx, "hold_cmd_ready", 32'(cmd_ready), 32'd0);
                chk(idx, "hold_valid", 32'(valid), 32'd0);
            end
            cmd_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk(idx, "rsp_consumed", 32'(rsp_valid), 32'd0);
        chk(idx, "cmd_ready_back", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             wr    data           dly inj hold e_data          err   mis   to    occ
        tbl_a[0]  = '{1'b0, 32'h0,          2,  0,  0,  32'h0,          1'b1, 1'b0, 1'b0, 3'd0};
        tbl_a[1]  = '{1'b1, 32'hA5A5_0001,  0,  0,  0,  32'h0,          1'b0, 1'b0, 1'b0, 3'd1};
        tbl_a[2]  = '{1'b0, 32'h0,          3,  0,  0,  32'hA5A5_0001,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl_a[3]  = '{1'b1, 32'h0000_0011,  1,  0,  0,  32'h0,          1'b0, 1'b0, 1'b0, 3'd1};
        tbl_a[4]  = '{1'b1, 32'h0000_0022,  5,  0,  0,  32'h0,          1'b0, 1'b0, 1'b0, 3'd2};
        tbl_a[5]  = '{1'b1, 32'h0000_0033,  7,  0,  0,  32'h0,          1'b0, 1'b0, 1'b0, 3'd3};
        tbl_a[6]  = '{1'b1, 32'h0000_0044,  0,  0,  10, 32'h0,          1'b0, 1'b0, 1'b0, 3'd4};
        tbl_a[7]  = '{1'b1, 32'h0000_0055,  2,  0,  0,  32'h0,          1'b1, 1'b0, 1'b0, 3'd4};
        tbl_a[8]  = '{1'b0, 32'h0,          4,  0,  0,  32'h0000_0044,  1'b0, 1'b0, 1'b0, 3'd3};
        tbl_a[9]  = '{1'b0, 32'h0,          6,  0,  0,  32'h0000_0033,  1'b0, 1'b0, 1'b0, 3'd2};
        tbl_a[10] = '{1'b0, 32'h0,          0,  0,  0,  32'h0000_0022,  1'b0, 1'b0, 1'b0, 3'd1};
        tbl_a[11] = '{1'b0, 32'h0,          1,  0,  0,  32'h0000_0011,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl_a[12] = '{1'b1, 32'h0000_0066,  99, 0,  0,  32'h0,          1'b0, 1'b0, 1'b1, 3'd0};
        tbl_a[13] = '{1'b1, 32'h0000_0077,  15, 0,  0,  32'h0,          1'b0, 1'b0, 1'b0, 3'd1};
        tbl_a[14] = '{1'b0, 32'h0,          2,  1,  0,  32'h0,          1'b1, 1'b1, 1'b0, 3'd1};
        tbl_a[15] = '{1'b0, 32'h0,          0,  0,  0,  32'h0000_0077,  1'b0, 1'b0, 1'b0, 3'd0};
        tbl_a[16] = '{1'b0, 32'h0,          1,  2,  0,  32'hDEAD_BEEF,  1'b0, 1'b1, 1'b0, 3'd0};
        tbl_a[17] = '{1'b1, 32'h0000_1234,  3,  0,  0,  32'h0,          1'b0, 1'b0, 1'b0, 3'd1};
        tbl_b[0]  = '{1'b1, 32'h0000_0088,  0,  0,  0,  32'h0,          1'b0, 1'b0, 1'b0, 3'd1};
        tbl_b[1]  = '{1'b0, 32'h0,          2,  0,  0,  32'h0000_0088,  1'b0, 1'b0, 1'b0, 3'd0};

        n_chk     = 0;
        n_fail    = 0;
        sp        = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_data  = 32'h0;
        ready     = 1'b0;
        err       = 1'b0;
        data_rd   = 32'h0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk(100, "rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk(100, "rst_valid", 32'(valid), 32'd0);
        chk(100, "rst_write", 32'(write), 32'd0);
        chk(100, "rst_data_wr", data_wr, 32'd0);
        chk(100, "rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk(100, "rst_occupancy", 32'(occupancy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk(100, "first_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 18; i++) begin
            run_vec(i, tbl_a[i]);
        end

        // Asynchronous reset while a push request is outstanding
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_data  = 32'h0000_0099;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk(101, "pre_valid", 32'(valid), 32'd1);
        chk(101, "pre_occupancy", 32'(occupancy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk(101, "async_valid", 32'(valid), 32'd0);
        chk(101, "async_occupancy", 32'(occupancy), 32'd0);
        chk(101, "async_cmd_ready", 32'(cmd_ready), 32'd0);
        chk(101, "async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk(101, "async_data_wr", data_wr, 32'd0);
        sp = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk(101, "post_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 2; i++) begin
            run_vec(200 + i, tbl_b[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
